mem_arbiter: RTL and testbench

- Sits directly downstream of the data cache and beside the instruction cache; consumes their caches_if-side requests and drives the single-ported RAM.
- Arbitrates between icache (single-word reads) and dcache (two-word block reads/writebacks, single-word flush/counter writes).
- Locks the grant across a dcache two-word block so the block's words are never interleaved with icache traffic.
- Bounds icache starvation with a saturating wait counter.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/starve_ctr.sv | 30 +++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Types and constants shared by the caches and the memory arbiter.
package cpu_types_pkg;

    localparam int unsigned WORD_W       = 32;
    localparam int unsigned BLK_WORD_BIT = 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_D = 2'd1,
        GNT_I = 2'd2
    } arb_state_t;

    // Memory-mapped counter location the dcache writes on halt.
    localparam word_t CNT_ADDR = 32'h0000_3100;

endpackage

// File: rtl/starve_ctr.sv
// Saturating wait counter: clear has priority over increment, holds at all-ones.
module starve_ctr #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_sat   = (r_count == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache, with dcache block lock
// and bounded icache starvation.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              ram_err
);

    arb_state_t       r_state;
    arb_state_t       w_next;
    ramstate_t        w_rs;
    logic             w_dreq;
    logic             w_access;
    logic             w_error;
    logic             w_starved;
    logic             w_inc;
    logic             w_clr;
    logic             w_sat;
    logic [CNT_W-1:0] w_count;
    logic             r_err;

    assign w_rs     = ramstate_t'(ramstate);
    assign w_dreq   = dREN | dWEN;
    assign w_access = (w_rs == ACCESS);
    assign w_error  = (w_rs == ERROR);

    // Wait accrues while icache is asking but not being served.
    assign w_inc = iREN && (r_state != GNT_I);
    assign w_clr = !iREN || ((r_state == GNT_I) && w_access);

    starve_ctr #(
        .CNT_W (CNT_W)
    ) u_starve (
        .CLK     (CLK),
        .nRST    (nRST),
        .i_inc   (w_inc),
        .i_clr   (w_clr),
        .o_count (w_count),
        .o_sat   (w_sat)
    );

    assign w_starved = w_sat || (w_count >= CNT_W'(STARVE_MAX));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grant decision and RAM port muxing; starvation only wins from IDLE.
    always_comb begin
        w_next   = r_state;
        iwait    = 1'b1;
        dwait    = 1'b1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (r_state)
            IDLE: begin
                if (iREN && w_starved) begin
                    w_next = GNT_I;
                end else if (w_dreq) begin
                    w_next = GNT_D;
                end else if (iREN) begin
                    w_next = GNT_I;
                end else begin
                    w_next = IDLE;
                end
            end
            GNT_D: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~w_access;
                // Hold the grant after the first word so the block stays contiguous.
                if (!w_dreq) begin
                    w_next = IDLE;
                end else if (w_access && daddr[BLK_WORD_BIT]) begin
                    w_next = IDLE;
                end
            end
            GNT_I: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                iwait   = ~w_access;
                if (w_access || !iREN) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_err <= 1'b0;
        end else if ((r_state != IDLE) && w_error) begin
            r_err <= 1'b1;
        end
    end

    assign ram_err = r_err;
    assign iload   = ramload;
    assign dload   = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written multi-cycle
// sequences, and random traffic against a grant-owner reference model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int unsigned STARVE_MAX = 8;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned STARVE_SAT = 15;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, ram_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .ram_err  (ram_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic set_in(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                          input logic [31:0] da, input logic [31:0] ds,
                          input logic [1:0] rs, input logic [31:0] rl);
        iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
        daddr = da; dstore = ds; ramstate = rs; ramload = rl;
    endtask

    // Reference: who owns the RAM (0 none, 1 dcache, 2 icache), icache wait, error flag.
    int          m_owner;
    int unsigned m_starve;
    bit          m_err;

    task automatic model_reset();
        m_owner = 0; m_starve = 0; m_err = 1'b0;
    endtask

    task automatic model_step();
        int nxt;
        bit acc;
        bit dreq;
        acc  = (ramstate == ACCESS);
        dreq = dREN || dWEN;
        if (!nRST) begin
            model_reset();
            return;
        end
        if (m_owner != 0 && ramstate == ERROR) m_err = 1'b1;
        if (m_owner == 0)
            nxt = (iREN && m_starve >= STARVE_MAX) ? 2 : (dreq ? 1 : (iREN ? 2 : 0));
        else if (m_owner == 1)
            nxt = (!dreq || (acc && daddr[2])) ? 0 : 1;
        else
            nxt = (acc || !iREN) ? 0 : 2;
        if (!iREN || (m_owner == 2 && acc)) m_starve = 0;
        else if (m_owner != 2 && m_starve < STARVE_SAT) m_starve++;
        m_owner = nxt;
    endtask

    task automatic model_check(input string tag);
        logic        e_iw, e_dw, e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        e_iw = 1'b1; e_dw = 1'b1; e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
        if (m_owner == 1) begin
            e_addr = daddr; e_store = dstore; e_wen = dWEN; e_ren = dREN && !dWEN;
            e_dw = (ramstate != ACCESS);
        end else if (m_owner == 2) begin
            e_addr = iaddr; e_ren = 1'b1; e_iw = (ramstate != ACCESS);
        end
        check({tag, ".iwait"},    32'(iwait),    32'(e_iw));
        check({tag, ".dwait"},    32'(dwait),    32'(e_dw));
        check({tag, ".ramREN"},   32'(ramREN),   32'(e_ren));
        check({tag, ".ramWEN"},   32'(ramWEN),   32'(e_wen));
        check({tag, ".ramaddr"},  ramaddr,       e_addr);
        check({tag, ".ramstore"}, ramstore,      e_store);
        check({tag, ".ram_err"},  32'(ram_err),  32'(m_err));
        check({tag, ".iload"},    iload,         ramload);
        check({tag, ".dload"},    dload,         ramload);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr, dw;
        logic [31:0] da, ds;
        logic [1:0]  rs;
        logic [31:0] rl;
        logic        e_iw, e_dw, e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                                input logic [31:0] da, input logic [31:0] ds, input logic [1:0] rs,
                                input logic [31:0] rl, input logic eiw, input logic edw,
                                input logic eren, input logic ewen, input logic [31:0] eaddr,
                                input logic [31:0] estore, input logic eerr);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.ds = ds; v.rs = rs; v.rl = rl;
        v.e_iw = eiw; v.e_dw = edw; v.e_ren = eren; v.e_wen = ewen;
        v.e_addr = eaddr; v.e_store = estore; v.e_err = eerr;
        return v;
    endfunction

    vec_t vecs[21];

    initial begin
        int          first_i;
        int          second_i;
        int          n_igrant;
        bit          wsel;
        int unsigned r;

        // icache single read
        vecs[0]  = mk(1, 32'h40, 0, 0, 0, 0, FREE,   0,            1, 1, 0, 0, 0,     0, 0);
        vecs[1]  = mk(1, 32'h40, 0, 0, 0, 0, BUSY,   0,            1, 1, 1, 0, 32'h40, 0, 0);
        vecs[2]  = mk(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'hDEADBEEF, 0, 1, 1, 0, 32'h40, 0, 0);
        vecs[3]  = mk(0, 32'h40, 0, 0, 0, 0, FREE,   0,            1, 1, 0, 0, 0,     0, 0);
        // dcache block with icache waiting
        vecs[4]  = mk(1, 32'h80, 1, 0, 32'h100, 0, FREE,   0,     1, 1, 0, 0, 0,      0, 0);
        vecs[5]  = mk(1, 32'h80, 1, 0, 32'h100, 0, BUSY,   0,     1, 1, 1, 0, 32'h100, 0, 0);
        vecs[6]  = mk(1, 32'h80, 1, 0, 32'h100, 0, ACCESS, 32'h11, 1, 0, 1, 0, 32'h100, 0, 0);
        vecs[7]  = mk(1, 32'h80, 1, 0, 32'h104, 0, ACCESS, 32'h22, 1, 0, 1, 0, 32'h104, 0, 0);
        vecs[8]  = mk(1, 32'h80, 0, 0, 32'h104, 0, FREE,   0,     1, 1, 0, 0, 0,      0, 0);
        vecs[9]  = mk(1, 32'h80, 0, 0, 32'h104, 0, ACCESS, 32'h33, 0, 1, 1, 0, 32'h80, 0, 0);
        vecs[10] = mk(0, 32'h80, 0, 0, 0, 0,       FREE,   0,     1, 1, 0, 0, 0,      0, 0);
        // counter write with both strobes
        vecs[11] = mk(0, 0, 1, 1, CNT_ADDR, 5, FREE,   0, 1, 1, 0, 0, 0,        0, 0);
        vecs[12] = mk(0, 0, 1, 1, CNT_ADDR, 5, ACCESS, 0, 1, 0, 0, 1, CNT_ADDR, 5, 0);
        vecs[13] = mk(0, 0, 0, 0, CNT_ADDR, 5, FREE,   0, 1, 1, 0, 0, CNT_ADDR, 5, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0,        FREE,   0, 1, 1, 0, 0, 0,        0, 0);
        // ERROR retry then ACCESS
        vecs[15] = mk(0, 0, 1, 0, 32'h200, 0, FREE,   0,      1, 1, 0, 0, 0,       0, 0);
        vecs[16] = mk(0, 0, 1, 0, 32'h200, 0, ERROR,  0,      1, 1, 1, 0, 32'h200, 0, 0);
        vecs[17] = mk(0, 0, 1, 0, 32'h200, 0, ERROR,  0,      1, 1, 1, 0, 32'h200, 0, 1);
        vecs[18] = mk(0, 0, 1, 0, 32'h200, 0, ACCESS, 32'h44, 1, 0, 1, 0, 32'h200, 0, 1);
        vecs[19] = mk(0, 0, 0, 0, 32'h200, 0, FREE,   0,      1, 1, 0, 0, 32'h200, 0, 1);
        vecs[20] = mk(0, 0, 0, 0, 0, 0,       FREE,   0,      1, 1, 0, 0, 0,       0, 1);

        set_in(1, 32'h40, 1, 1, 32'h100, 32'h77, ACCESS, 32'hA5A5A5A5);
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst.iwait",    32'(iwait),   32'd1);
        check("rst.dwait",    32'(dwait),   32'd1);
        check("rst.ramREN",   32'(ramREN),  32'd0);
        check("rst.ramWEN",   32'(ramWEN),  32'd0);
        check("rst.ramaddr",  ramaddr,      32'd0);
        check("rst.ramstore", ramstore,     32'd0);
        check("rst.ram_err",  32'(ram_err), 32'd0);
        check("rst.iload",    iload,        32'hA5A5A5A5);
        check("rst.dload",    dload,        32'hA5A5A5A5);
        set_in(0, 0, 0, 0, 0, 0, FREE, 0);
        nRST = 1'b1;
        tick();

        for (int i = 0; i < 21; i++) begin
            set_in(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw,
                   vecs[i].da, vecs[i].ds, vecs[i].rs, vecs[i].rl);
            @(negedge CLK);
            check($sformatf("row%0d.iwait", i),    32'(iwait),   32'(vecs[i].e_iw));
            check($sformatf("row%0d.dwait", i),    32'(dwait),   32'(vecs[i].e_dw));
            check($sformatf("row%0d.ramREN", i),   32'(ramREN),  32'(vecs[i].e_ren));
            check($sformatf("row%0d.ramWEN", i),   32'(ramWEN),  32'(vecs[i].e_wen));
            check($sformatf("row%0d.ramaddr", i),  ramaddr,      vecs[i].e_addr);
            check($sformatf("row%0d.ramstore", i), ramstore,     vecs[i].e_store);
            check($sformatf("row%0d.ram_err", i),  32'(ram_err), 32'(vecs[i].e_err));
            check($sformatf("row%0d.iload", i),    iload,        vecs[i].rl);
            check($sformatf("row%0d.dload", i),    dload,        vecs[i].rl);
            tick();
        end

        // Continuous dcache blocks with iREN held: icache forced in at cycles 10 and 21.
        first_i = -1; second_i = -1; n_igrant = 0; wsel = 1'b0;
        for (int c = 0; c < 30; c++) begin
            set_in(1, 32'h80, 1, 0, wsel ? 32'h104 : 32'h100, 0, ACCESS, 32'(c));
            @(negedge CLK);
            model_check("starve");
            if (iwait == 1'b0) begin
                if (n_igrant == 0) first_i = c;
                else if (n_igrant == 1) second_i = c;
                n_igrant++;
            end
            if (dwait == 1'b0) wsel = ~wsel;
            tick();
        end
        check("starve.first_igrant",  32'(first_i),  32'd10);
        check("starve.second_igrant", 32'(second_i), 32'd21);

        for (int c = 0; c < 2; c++) begin
            set_in(0, 0, 0, 0, 0, 0, FREE, 0);
            @(negedge CLK);
            model_check("quiesce");
            tick();
        end

        // Reset after the first word of a block, with an ERROR seen earlier.
        set_in(0, 0, 1, 0, 32'h100, 0, FREE, 0);
        @(negedge CLK); model_check("rblk.idle");  tick();
        ramstate = ERROR;
        @(negedge CLK); model_check("rblk.err");   tick();
        ramstate = ACCESS;
        @(negedge CLK); model_check("rblk.w0");    tick();
        set_in(1, 32'h80, 1, 0, 32'h104, 0, BUSY, 32'h55);
        @(negedge CLK); model_check("rblk.w1");
        #2 nRST = 1'b0;
        model_reset();
        #1;
        check("rmid.ramREN",  32'(ramREN),  32'd0);
        check("rmid.ramWEN",  32'(ramWEN),  32'd0);
        check("rmid.dwait",   32'(dwait),   32'd1);
        check("rmid.iwait",   32'(iwait),   32'd1);
        check("rmid.ramaddr", ramaddr,      32'd0);
        check("rmid.ram_err", 32'(ram_err), 32'd0);
        tick();
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        model_check("rrel");
        tick();
        ramstate = ACCESS;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK); model_check("rpost"); tick();
        end

        // Random traffic with sticky requests so starvation and locking both occur.
        set_in(0, 0, 0, 0, 0, 0, FREE, 0);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) iREN = ~iREN;
            if ($urandom_range(0, 4) == 0) begin
                dREN = 1'($urandom_range(0, 1));
                dWEN = 1'($urandom_range(0, 3) == 0);
            end
            iaddr   = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            daddr   = 32'($urandom_range(0, 255)) << 2;
            dstore  = $urandom;
            ramload = $urandom;
            r = $urandom_range(0, 19);
            ramstate = (r < 4) ? FREE : (r < 9) ? BUSY : (r < 19) ? ACCESS : ERROR;
            @(negedge CLK);
            model_check("rand");
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
